io_mem_arbiter: RTL

Two-port Avalon-MM burst arbiter sharing the single FPGA-side SDRAM master port of the `io_mem` system (HPS DDR3) between two numerical-pipeline requesters (port 0, port 1). It applies round-robin arbitration per command, locks the grant for the full length of a write burst, and routes in-order read responses back to the issuing requester through a pending-read FIFO. It sits between the solver datapath and the `io_mem` SDRAM slave and runs in the `clk_clk` domain.

---
 rtl/io_mem_arb_pkg.sv | 20 ++
 rtl/io_mem_rsp_fifo.sv | 74 +++++++
 rtl/io_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/io_mem_arb_pkg.sv
// Shared types for the io_mem two-port burst arbiter.
package io_mem_arb_pkg;

    // Width of the burstcount field stored per pending read.
    localparam int unsigned ArbBurstW = 4;

    typedef enum logic [0:0] {
        StIdle,
        StWrBurst
    } arb_state_e;

    typedef logic req_id_t;

    // One outstanding read: who issued it and how many beats come back.
    typedef struct packed {
        req_id_t                id;
        logic [ArbBurstW-1:0]   burstcount;
    } pend_entry_t;

endpackage

// File: rtl/io_mem_rsp_fifo.sv
// Synchronous pending-read FIFO with same-cycle push/pop (legal when full).
module io_mem_rsp_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A push into a full FIFO is fine when the head leaves the same cycle.
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/io_mem_arbiter.sv
// Two-port Avalon-MM burst arbiter in front of the io_mem SDRAM master port.
module io_mem_arbiter
    import io_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 29,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned BURST_W    = 4,
    parameter int unsigned PEND_DEPTH = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset,

    input  logic [ADDR_W-1:0]   r0_address,
    input  logic                r0_read,
    input  logic                r0_write,
    input  logic [DATA_W-1:0]   r0_writedata,
    input  logic [DATA_W/8-1:0] r0_byteenable,
    input  logic [BURST_W-1:0]  r0_burstcount,
    output logic                r0_waitrequest,
    output logic [DATA_W-1:0]   r0_readdata,
    output logic                r0_readdatavalid,

    input  logic [ADDR_W-1:0]   r1_address,
    input  logic                r1_read,
    input  logic                r1_write,
    input  logic [DATA_W-1:0]   r1_writedata,
    input  logic [DATA_W/8-1:0] r1_byteenable,
    input  logic [BURST_W-1:0]  r1_burstcount,
    output logic                r1_waitrequest,
    output logic [DATA_W-1:0]   r1_readdata,
    output logic                r1_readdatavalid,

    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [BURST_W-1:0]  m_burstcount,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,

    output logic                rsp_err
);

    localparam logic [BURST_W-1:0]   BcOne  = BURST_W'(1);
    localparam logic [ArbBurstW:0]   CntOne = (ArbBurstW + 1)'(1);

    arb_state_e             state_q, state_d;
    req_id_t                last_grant_q, last_grant_d;
    req_id_t                owner_q, owner_d;
    logic [BURST_W-1:0]     beats_left_q, beats_left_d;
    logic [ArbBurstW-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   elig0, elig1;
    logic                   gnt_valid;
    req_id_t                gnt_id;
    logic                   sel_read, sel_write;
    logic [BURST_W-1:0]     sel_bc;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   fifo_full, fifo_empty;
    pend_entry_t            push_entry;
    pend_entry_t            head;
    logic                   rsp_beat;
    logic                   rsp_last;
    logic [ArbBurstW:0]     rsp_cnt_inc;

    // Reads are held off while the FIFO is full, even if a pop is in flight.
    assign elig0 = r0_write || (r0_read && !fifo_full);
    assign elig1 = r1_write || (r1_read && !fifo_full);

    // Grant selection: round-robin in IDLE, locked to the owner mid-burst.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        case (state_q)
            StIdle: begin
                if (elig0 && elig1) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ~last_grant_q;
                end else if (elig0) begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b0;
                end else if (elig1) begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b1;
                end
            end
            StWrBurst: begin
                gnt_valid = 1'b1;
                gnt_id    = owner_q;
            end
            default: ;
        endcase
        // Keep the master port quiet while reset is held.
        if (reset_reset) begin
            gnt_valid = 1'b0;
        end
    end

    // Command mux to the master port and per-requester stalls.
    always_comb begin
        sel_read     = gnt_id ? r1_read       : r0_read;
        sel_write    = gnt_id ? r1_write      : r0_write;
        sel_bc       = gnt_id ? r1_burstcount : r0_burstcount;
        m_address    = gnt_id ? r1_address    : r0_address;
        m_writedata  = gnt_id ? r1_writedata  : r0_writedata;
        m_byteenable = gnt_id ? r1_byteenable : r0_byteenable;
        m_burstcount = sel_bc;
        m_read       = gnt_valid && sel_read && (state_q == StIdle);
        m_write      = gnt_valid && sel_write;
        r0_waitrequest = !(gnt_valid && (gnt_id == 1'b0)) || m_waitrequest;
        r1_waitrequest = !(gnt_valid && (gnt_id == 1'b1)) || m_waitrequest;
        accept       = (m_read || m_write) && !m_waitrequest;
    end

    // Arbitration FSM next-state: burst lock, beat counting, read tagging.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        push         = 1'b0;
        push_entry.id         = gnt_id;
        push_entry.burstcount = ArbBurstW'(sel_bc);
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (m_read) begin
                        push         = 1'b1;
                        last_grant_d = gnt_id;
                    end else if (sel_bc > BcOne) begin
                        beats_left_d = sel_bc - BcOne;
                        owner_d      = gnt_id;
                        state_d      = StWrBurst;
                    end else begin
                        last_grant_d = gnt_id;
                    end
                end
            end
            StWrBurst: begin
                if (accept) begin
                    beats_left_d = beats_left_q - BcOne;
                    if (beats_left_q <= BcOne) begin
                        last_grant_d = owner_q;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response routing: beats go to the head entry's requester until its burst is done.
    always_comb begin
        rsp_beat    = m_readdatavalid && !fifo_empty && !reset_reset;
        rsp_cnt_inc = {1'b0, rsp_cnt_q} + CntOne;
        // A zero burstcount is treated as a single beat.
        rsp_last    = rsp_cnt_inc >= {1'b0, head.burstcount};
        pop         = rsp_beat && rsp_last;
        rsp_cnt_d   = rsp_cnt_q;
        if (rsp_beat) begin
            rsp_cnt_d = rsp_last ? '0 : rsp_cnt_inc[ArbBurstW-1:0];
        end
        rsp_err_d   = rsp_err_q || (m_readdatavalid && fifo_empty);
        r0_readdata      = m_readdata;
        r1_readdata      = m_readdata;
        r0_readdatavalid = rsp_beat && (head.id == 1'b0);
        r1_readdatavalid = rsp_beat && (head.id == 1'b1);
    end

    assign rsp_err = rsp_err_q;

    // Arbitration and response state registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            beats_left_q <= '0;
            rsp_cnt_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
            rsp_cnt_q    <= rsp_cnt_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    io_mem_rsp_fifo #(
        .WIDTH ($bits(pend_entry_t)),
        .DEPTH (PEND_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
